// File: rtl/lbm_pkg.sv
// Shared lattice-Boltzmann types: cell density vector, lattice defaults and
// the sweep controller state encoding.
package lbm_pkg;
  localparam int NUM_DIRS       = 9;
  localparam int DENS_W         = 8;
  localparam int GRID_W_DEFAULT = 128;
  localparam int GRID_H_DEFAULT = 96;

  typedef logic [NUM_DIRS-1:0][DENS_W-1:0] cell_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } sweep_state_t;
endpackage

// File: rtl/addr_fifo.sv
// Synchronous FIFO holding cell addresses between BRAM read-out and the
// collision stage's write-back. DEPTH must be a power of two, >= 2.
module addr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // a pop in the same cycle frees the slot, so a push into a full FIFO is legal then
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/collision_sweep_ctrl.sv
// Sweeps every lattice cell: BRAM read -> collision stage -> BRAM write-back.
// Optional macro COLLISION_SWEEP_PERF_EN adds the sweep_cycles_out counter.
//
// state   | meaning
// IDLE    | waiting for start_in
// RUN     | issuing reads in ascending cell order, throttled by FIFO space
// DRAIN   | all reads issued; waiting for reads and collisions to retire
// DONE    | one-cycle end-of-sweep pulse
module collision_sweep_ctrl
  import lbm_pkg::*;
#(
  parameter  int GRID_W     = GRID_W_DEFAULT,
  parameter  int GRID_H     = GRID_H_DEFAULT,
  parameter  int RD_LAT     = 2,
  parameter  int FIFO_DEPTH = 32,
  localparam int N_CELLS    = GRID_W * GRID_H,
  localparam int ADDR_W     = $clog2(N_CELLS)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  output logic              busy_out,
  output logic              done_out,
  output logic              err_out,
  output logic [ADDR_W-1:0] bram_raddr_out,
  output logic              bram_ren_out,
  input  cell_t             bram_rdata_in,
  output cell_t             coll_data_out,
  output logic              coll_valid_out,
  input  cell_t             coll_data_in,
  input  logic              coll_done_in,
  output logic [ADDR_W-1:0] bram_waddr_out,
  output cell_t             bram_wdata_out,
  output logic              bram_we_out
`ifdef COLLISION_SWEEP_PERF_EN
  ,
  output logic [31:0]       sweep_cycles_out
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  sweep_state_t      state;
  sweep_state_t      state_nxt;
  logic [ADDR_W-1:0] rd_addr;
  logic [CW-1:0]     in_flight;
  logic [RD_LAT-1:0] dl_valid;
  logic [ADDR_W-1:0] dl_addr [RD_LAT];
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic [ADDR_W-1:0] fifo_head;
  logic [CW:0]       pressure;
  logic              issue;
  logic              dl_out;
  logic              pop_ok;
  logic              accept;
  logic              armed;

  assign pressure = {1'b0, in_flight} + {1'b0, fifo_count};
  assign dl_out   = dl_valid[RD_LAT-1];
  assign pop_ok   = coll_done_in && !fifo_empty;
  assign accept   = (state == S_IDLE) && start_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      S_IDLE:  if (start_in) state_nxt = S_RUN;
      S_RUN: begin
        issue = !fifo_full && (pressure < (CW+1)'(FIFO_DEPTH));
        if (issue && rd_addr == ADDR_W'(N_CELLS - 1)) state_nxt = S_DRAIN;
      end
      S_DRAIN: if (in_flight == '0 && fifo_empty) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bram_ren_out   = issue;
  assign bram_raddr_out = rd_addr;
  assign busy_out       = (state == S_RUN) || (state == S_DRAIN);
  assign done_out       = (state == S_DONE);
  assign coll_valid_out = dl_out;
  assign coll_data_out  = dl_out ? bram_rdata_in : '0;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_addr   <= '0;
      in_flight <= '0;
      dl_valid  <= '0;
    end else begin
      if (accept)     rd_addr <= '0;
      else if (issue) rd_addr <= rd_addr + 1'b1;
      if (issue && !dl_out)      in_flight <= in_flight + 1'b1;
      else if (!issue && dl_out) in_flight <= in_flight - 1'b1;
      dl_valid[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) dl_valid[i] <= dl_valid[i-1];
    end
  end

  always_ff @(posedge clk_in) begin
    dl_addr[0] <= rd_addr;
    for (int i = 1; i < RD_LAT; i++) dl_addr[i] <= dl_addr[i-1];
  end

  addr_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_addr_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (dl_out),
    .push_data (dl_addr[RD_LAT-1]),
    .pop       (pop_ok),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // armed keeps stale collision results after a reset from raising err_out
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bram_we_out    <= 1'b0;
      bram_waddr_out <= '0;
      bram_wdata_out <= '0;
      err_out        <= 1'b0;
      armed          <= 1'b0;
    end else begin
      bram_we_out <= pop_ok;
      if (pop_ok) begin
        bram_waddr_out <= fifo_head;
        bram_wdata_out <= coll_data_in;
      end
      if (coll_done_in && fifo_empty && armed) err_out <= 1'b1;
      if (accept) armed <= 1'b1;
    end
  end

`ifdef COLLISION_SWEEP_PERF_EN
  logic [31:0] cyc_cnt;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cyc_cnt          <= '0;
      sweep_cycles_out <= '0;
    end else begin
      if (accept)        cyc_cnt <= '0;
      else if (busy_out) cyc_cnt <= cyc_cnt + 1'b1;
      if (state == S_DONE) sweep_cycles_out <= cyc_cnt;
    end
  end
`endif
endmodule

// File: tb/tb_collision_sweep_ctrl.sv
// Scoreboard bench: a 4x2 instance for functional cases and a default-size
// instance for the FIFO back-pressure sweep.
module tb_collision_sweep_ctrl;
  import lbm_pkg::*;

  localparam int SN    = 8;
  localparam int SA    = 3;
  localparam int BN    = 12288;
  localparam int BA    = 14;
  localparam int DEPTH = 32;
  localparam int S_LAT = 20;
  localparam int B_LAT = 40;

  typedef struct {
    int          a;
    logic [71:0] d;
  } wr_t;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int vectors     = 0;
  int miscompares = 0;

  // small instance
  logic          s_rst, s_start, s_busy, s_done, s_err, s_ren, s_cvalid, s_cdone, s_we;
  logic [SA-1:0] s_raddr, s_waddr;
  logic [71:0]   s_rdata, s_cdata_out, s_cdata_in, s_wdata;
  // big instance
  logic          b_rst, b_start, b_busy, b_done, b_err, b_ren, b_cvalid, b_cdone, b_we;
  logic [BA-1:0] b_raddr, b_waddr;
  logic [71:0]   b_rdata, b_cdata_out, b_cdata_in, b_wdata;
`ifdef COLLISION_SWEEP_PERF_EN
  logic [31:0]   s_cycles, b_cycles;
`endif

  collision_sweep_ctrl #(.GRID_W(4), .GRID_H(2), .RD_LAT(2), .FIFO_DEPTH(DEPTH)) u_small (
    .clk_in(clk_in), .rst_in(s_rst), .start_in(s_start), .busy_out(s_busy),
    .done_out(s_done), .err_out(s_err), .bram_raddr_out(s_raddr), .bram_ren_out(s_ren),
    .bram_rdata_in(s_rdata), .coll_data_out(s_cdata_out), .coll_valid_out(s_cvalid),
    .coll_data_in(s_cdata_in), .coll_done_in(s_cdone), .bram_waddr_out(s_waddr),
    .bram_wdata_out(s_wdata), .bram_we_out(s_we)
`ifdef COLLISION_SWEEP_PERF_EN
    , .sweep_cycles_out(s_cycles)
`endif
  );

  collision_sweep_ctrl u_big (
    .clk_in(clk_in), .rst_in(b_rst), .start_in(b_start), .busy_out(b_busy),
    .done_out(b_done), .err_out(b_err), .bram_raddr_out(b_raddr), .bram_ren_out(b_ren),
    .bram_rdata_in(b_rdata), .coll_data_out(b_cdata_out), .coll_valid_out(b_cvalid),
    .coll_data_in(b_cdata_in), .coll_done_in(b_cdone), .bram_waddr_out(b_waddr),
    .bram_wdata_out(b_wdata), .bram_we_out(b_we)
`ifdef COLLISION_SWEEP_PERF_EN
    , .sweep_cycles_out(b_cycles)
`endif
  );

  function automatic logic [71:0] rep(input int a);
    logic [7:0] b;
    b = 8'(a);
    return {9{b}};
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // BRAM (2-cycle read latency) and fixed-latency collision models for both instances.
  // Collision result = bitwise inverse of the densities it was handed.
  logic        s_inj = 1'b0;
  logic        s_cap_v = 1'b0, s_rv0 = 1'b0, s_rv1 = 1'b0, s_smp_v = 1'b0;
  int          s_cap_a = 0, s_ra0 = 0, s_ra1 = 0;
  logic [71:0] s_smp_d = '0;
  logic        s_cp_v [64];
  logic [71:0] s_cp_d [64];
  logic        b_cap_v = 1'b0, b_smp_v = 1'b0;
  int          b_cap_a = 0, b_ra0 = 0, b_ra1 = 0;
  logic [71:0] b_smp_d = '0;
  logic        b_cp_v [64];
  logic [71:0] b_cp_d [64];

  initial begin
    for (int i = 0; i < 64; i++) begin
      s_cp_v[i] = 1'b0; s_cp_d[i] = '0; b_cp_v[i] = 1'b0; b_cp_d[i] = '0;
    end
    s_rdata = '0; s_cdone = 1'b0; s_cdata_in = '0;
    b_rdata = '0; b_cdone = 1'b0; b_cdata_in = '0;
    forever begin
      @(posedge clk_in); #1;
      s_rv1 = s_rv0; s_ra1 = s_ra0; s_rv0 = s_cap_v; s_ra0 = s_cap_a;
      s_rdata = rep(s_ra1);
      b_ra1 = b_ra0; b_ra0 = b_cap_a;
      b_rdata = rep(b_ra1);
      for (int i = 63; i > 0; i--) begin
        s_cp_v[i] = s_cp_v[i-1]; s_cp_d[i] = s_cp_d[i-1];
        b_cp_v[i] = b_cp_v[i-1]; b_cp_d[i] = b_cp_d[i-1];
      end
      s_cp_v[0] = s_smp_v; s_cp_d[0] = s_smp_d;
      b_cp_v[0] = b_smp_v; b_cp_d[0] = b_smp_d;
      s_cdone    = s_cp_v[S_LAT-1] | s_inj;
      s_cdata_in = ~s_cp_d[S_LAT-1];
      b_cdone    = b_cp_v[B_LAT-1];
      b_cdata_in = ~b_cp_d[B_LAT-1];
      @(negedge clk_in);
      s_cap_v = s_ren; s_cap_a = int'(s_raddr);
      s_smp_v = s_cvalid; s_smp_d = s_cdata_out;
      b_cap_v = b_ren; b_cap_a = int'(b_raddr);
      b_smp_v = b_cvalid; b_smp_d = b_cdata_out;
    end
  end

  // scoreboards
  wr_t s_exp_q[$];
  wr_t b_exp_q[$];
  int  s_done_cnt = 0, s_wr_cnt = 0;
  int  b_done_cnt = 0, b_wr_cnt = 0;
  int  b_issued = 0, b_returned = 0, b_max_out = 0, b_stalls = 0, b_viol = 0;

  initial begin
    wr_t e;
    forever begin
      @(negedge clk_in);
      if (s_done) s_done_cnt++;
      if (s_we) begin
        s_wr_cnt++;
        vectors++;
        if (s_exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL s_write_unexpected: got addr %0d data %h, required no write", s_waddr, s_wdata);
        end else begin
          e = s_exp_q.pop_front();
          if (int'(s_waddr) != e.a || s_wdata !== e.d) begin
            miscompares++;
            $display("FAIL s_write: got addr %0d data %h, required addr %0d data %h", s_waddr, s_wdata, e.a, e.d);
          end
        end
      end
    end
  end

  initial begin
    wr_t e;
    int  out;
    forever begin
      @(negedge clk_in);
      out = b_issued - b_returned;
      if (b_ren) begin
        if (out >= DEPTH) b_viol++;
      end else if (b_busy && b_issued < BN) begin
        if (out != DEPTH) b_viol++;
        else b_stalls++;
      end
      if (out > b_max_out) b_max_out = out;
      if (b_ren) b_issued++;
      if (b_cdone) b_returned++;
      if (b_done) b_done_cnt++;
      if (b_we) begin
        b_wr_cnt++;
        vectors++;
        if (b_exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL b_write_unexpected: got addr %0d, required no write", b_waddr);
        end else begin
          e = b_exp_q.pop_front();
          if (int'(b_waddr) != e.a || b_wdata !== e.d) begin
            miscompares++;
            $display("FAIL b_write: got addr %0d data %h, required addr %0d data %h", b_waddr, b_wdata, e.a, e.d);
          end
        end
      end
    end
  end

  task automatic s_push_sweep();
    wr_t e;
    for (int i = 0; i < SN; i++) begin
      e.a = i; e.d = ~rep(i);
      s_exp_q.push_back(e);
    end
  endtask

  task automatic s_pulse_start();
    s_start = 1'b1;
    @(negedge clk_in);
    s_start = 1'b0;
  endtask

  task automatic s_wait_done(input int budget);
    int n = 0;
    while (!s_done && n < budget) begin @(negedge clk_in); n++; end
    check("s_done_reached", longint'(n < budget), 1);
  endtask

  initial begin
    int n, d0, w0;
    wr_t e;
    s_rst = 1'b1; s_start = 1'b0; b_rst = 1'b1; b_start = 1'b0;
    repeat (3) @(negedge clk_in);
    s_rst = 1'b0; b_rst = 1'b0;

    check("rst_busy_done_err", {s_busy, s_done, s_err}, 0);
    check("rst_we_ren_cvalid", {s_we, s_ren, s_cvalid}, 0);

    // basic 4x2 sweep, collision latency 20
    d0 = s_done_cnt; w0 = s_wr_cnt;
    s_push_sweep();
    s_pulse_start();
    check("busy_after_start", s_busy, 1);
    s_wait_done(200);
    @(negedge clk_in);
    check("done_pulse_width", s_done, 0);
    check("busy_after_done", s_busy, 0);
    @(negedge clk_in);
    check("sweep1_done_count", s_done_cnt - d0, 1);
    check("sweep1_writes", s_wr_cnt - w0, SN);
    check("sweep1_queue_left", s_exp_q.size(), 0);
    check("sweep1_err", s_err, 0);
`ifdef COLLISION_SWEEP_PERF_EN
    // 8 issue cycles + 2 read latency + 20 collision latency + 1 pop cycle
    check("sweep_cycles", s_cycles, 31);
`endif

    // start re-pulsed during RUN is ignored
    d0 = s_done_cnt; w0 = s_wr_cnt;
    s_push_sweep();
    s_pulse_start();
    repeat (2) @(negedge clk_in);
    s_pulse_start();
    s_wait_done(200);
    repeat (10) @(negedge clk_in);
    check("restart_writes", s_wr_cnt - w0, SN);
    check("restart_done_count", s_done_cnt - d0, 1);
    check("restart_idle", s_busy, 0);

    // reset at cell 5 abandons the sweep
    s_push_sweep();
    s_pulse_start();
    n = 0;
    while (!(s_ren && s_raddr == SA'(5)) && n < 50) begin @(negedge clk_in); n++; end
    check("reached_cell5", longint'(n < 50), 1);
    s_rst = 1'b1;
    @(negedge clk_in);
    s_rst = 1'b0;
    s_exp_q.delete();
    check("midrst_busy_done_err", {s_busy, s_done, s_err}, 0);
    check("midrst_we_ren_cvalid", {s_we, s_ren, s_cvalid}, 0);
    check("midrst_raddr", s_raddr, 0);
    w0 = s_wr_cnt;
    repeat (60) @(negedge clk_in);
    check("midrst_no_writes", s_wr_cnt - w0, 0);
    check("midrst_stale_done_no_err", s_err, 0);

    d0 = s_done_cnt;
    s_push_sweep();
    s_pulse_start();
    s_wait_done(200);
    repeat (3) @(negedge clk_in);
    check("resweep_writes", s_wr_cnt - w0, SN);
    check("resweep_queue_left", s_exp_q.size(), 0);
    check("resweep_done_count", s_done_cnt - d0, 1);

    // collision result while idle
    w0 = s_wr_cnt;
    s_inj = 1'b1;
    @(negedge clk_in);
    s_inj = 1'b0;
    repeat (3) @(negedge clk_in);
    check("idle_inject_err", s_err, 1);
    check("idle_inject_no_write", s_wr_cnt - w0, 0);
    repeat (5) @(negedge clk_in);
    check("err_sticky", s_err, 1);
    s_rst = 1'b1;
    @(negedge clk_in);
    s_rst = 1'b0;
    check("err_cleared_by_reset", s_err, 0);

    // default 128x96 with collision latency 40: reads throttle at 32 outstanding
    for (int i = 0; i < BN; i++) begin
      e.a = i; e.d = ~rep(i);
      b_exp_q.push_back(e);
    end
    b_start = 1'b1;
    @(negedge clk_in);
    b_start = 1'b0;
    n = 0;
    while (!b_done && n < 40000) begin @(negedge clk_in); n++; end
    check("big_done_reached", longint'(n < 40000), 1);
    repeat (3) @(negedge clk_in);
    check("big_writes", b_wr_cnt, BN);
    check("big_queue_left", b_exp_q.size(), 0);
    check("big_done_count", b_done_cnt, 1);
    check("big_err", b_err, 0);
    check("big_max_outstanding", b_max_out, DEPTH);
    check("big_stalled", longint'(b_stalls > 0), 1);
    check("big_throttle_violations", b_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end
endmodule
